// File: rtl/intc_nest.sv
// intc_nest: two-level nested interrupt controller with an SFR programming interface.
// Ports:
//   clk, reset_n            - clock; synchronous active-low reset
//   mem_sel, mem_addr,      - SFR bus: an access is mem_sel & ~mem_sfr_n,
//   mem_we_n, mem_rd_n,       decoded on mem_addr[7:0]; writes on the edge with
//   mem_sfr_n, mem_wdata      mem_we_n=0, reads return on mem_rdata one cycle later
//   mem_rdata, mem_ready_out- registered read data; always ready
//   int_ack_n, int_reti     - CPU vector acknowledge (active-low) and return-from-interrupt
//   int_req_n, int_so_num   - active-low request and its vector (0 when idle)
//   int_src                 - raw active-high interrupt sources
//   int_isr                 - in-service flags {hi, lo}
module intc_nest #(
    parameter int         NUM_SRC    = 5,
    parameter logic [7:0] IE_ADDR    = 8'hA8,
    parameter logic [7:0] IP_ADDR    = 8'hB8,
    parameter logic [7:0] IT_ADDR    = 8'hC8,
    parameter logic [7:0] PND_ADDR   = 8'hC9,
    parameter logic [7:0] VEC_BASE   = 8'h03,
    parameter logic [7:0] VEC_STRIDE = 8'h08
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mem_sel,
    input  logic [15:0]        mem_addr,
    input  logic               mem_we_n,
    input  logic               mem_rd_n,
    input  logic               mem_sfr_n,
    input  logic [7:0]         mem_wdata,
    output logic [7:0]         mem_rdata,
    output logic               mem_ready_out,
    input  logic               int_ack_n,
    input  logic               int_reti,
    output logic               int_req_n,
    output logic [7:0]         int_so_num,
    input  logic [NUM_SRC-1:0] int_src,
    output logic [1:0]         int_isr
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state_q, state_d;
    logic               ea_q;
    logic [NUM_SRC-1:0] ie_q, ip_q, it_q;
    logic [NUM_SRC-1:0] s_q, s_qq;
    logic [NUM_SRC-1:0] epend_q, epend_d;
    logic [1:0]         isr_q, isr_d;
    logic [2:0]         idx_q, idx_d;
    logic               lvl_q, lvl_d;
    logic [7:0]         vec_q, vec_d;
    logic [7:0]         rdata_q, rdata_d;

    logic               sfr_sel, wr_en;
    logic [NUM_SRC-1:0] pend, elig, hi_c, lo_c, cand, sel_hot, ack_hot;
    logic               hi_ok, lo_ok, ack_fire, latched_elig;
    logic [2:0]         win;
    logic [7:0]         ie_v, ip_v, it_v, pnd_v;
    logic               unused_bits;

    // Upper address byte and unimplemented write-data bits carry no meaning here.
    assign unused_bits = ^{mem_addr[15:8], mem_wdata};

    assign sfr_sel = mem_sel & ~mem_sfr_n;
    assign wr_en   = sfr_sel & ~mem_we_n;

    // Level sources follow the synchronized input; edge sources use the sticky latch.
    assign pend  = (it_q & epend_q) | (~it_q & s_q);
    assign elig  = pend & ie_q & {NUM_SRC{ea_q}};
    assign hi_c  = elig & ip_q;
    assign lo_c  = elig & ~ip_q;
    assign hi_ok = (|hi_c) & ~isr_q[1];
    assign lo_ok = (|lo_c) & ~isr_q[1] & ~isr_q[0];
    assign cand  = hi_ok ? hi_c : lo_c;

    assign ack_fire     = (state_q == REQ) & ~int_ack_n;
    assign ack_hot      = sel_hot & {NUM_SRC{ack_fire}};
    assign latched_elig = |(elig & sel_hot);

    // Set beats clear: a fresh edge in the same cycle as ack or EA=0 survives.
    assign epend_d = (it_q & s_q & ~s_qq) | (epend_q & ~ack_hot & {NUM_SRC{ea_q}});

    always_comb begin
        win = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (cand[i]) win = 3'(i);
    end

    always_comb begin
        sel_hot = '0;
        for (int i = 0; i < NUM_SRC; i++)
            sel_hot[i] = (idx_q == 3'(i));
    end

    always_comb begin
        ie_v = 8'h00;
        ip_v = 8'h00;
        it_v = 8'h00;
        pnd_v = 8'h00;
        ie_v[NUM_SRC-1:0] = ie_q;
        ie_v[7] = ea_q;
        ip_v[NUM_SRC-1:0] = ip_q;
        it_v[NUM_SRC-1:0] = it_q;
        pnd_v[NUM_SRC-1:0] = pend & ie_q;
        pnd_v[7] = isr_q[1];
    end

    always_comb begin
        rdata_d = rdata_q;
        if (!mem_rd_n)
            rdata_d = !sfr_sel                ? 8'h00 :
                      mem_addr[7:0] == IE_ADDR  ? ie_v  :
                      mem_addr[7:0] == IP_ADDR  ? ip_v  :
                      mem_addr[7:0] == IT_ADDR  ? it_v  :
                      mem_addr[7:0] == PND_ADDR ? pnd_v : 8'h00;
    end

    // Request FSM; reti is applied to the pre-cycle isr, then an ack sets its level on top.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lvl_d   = lvl_q;
        vec_d   = vec_q;
        isr_d   = int_reti ? (isr_q[1] ? {1'b0, isr_q[0]} : 2'b00) : isr_q;
        case (state_q)
            IDLE: begin
                if (hi_ok || lo_ok) begin
                    state_d = REQ;
                    idx_d   = win;
                    lvl_d   = hi_ok;
                    vec_d   = VEC_BASE + 8'(win) * VEC_STRIDE;
                end
            end
            REQ: begin
                if (ack_fire) begin
                    state_d = IDLE;
                    isr_d   = isr_d | (lvl_q ? 2'b10 : 2'b01);
                end else if (!latched_elig) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ea_q    <= 1'b0;
            ie_q    <= '0;
            ip_q    <= '0;
            it_q    <= '0;
            s_q     <= '0;
            s_qq    <= '0;
            epend_q <= '0;
            isr_q   <= 2'b00;
            idx_q   <= 3'd0;
            lvl_q   <= 1'b0;
            vec_q   <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            s_q     <= int_src;
            s_qq    <= s_q;
            epend_q <= epend_d;
            isr_q   <= isr_d;
            idx_q   <= idx_d;
            lvl_q   <= lvl_d;
            vec_q   <= vec_d;
            rdata_q <= rdata_d;
            if (wr_en && mem_addr[7:0] == IE_ADDR) begin
                ea_q <= mem_wdata[7];
                ie_q <= mem_wdata[NUM_SRC-1:0];
            end
            if (wr_en && mem_addr[7:0] == IP_ADDR) ip_q <= mem_wdata[NUM_SRC-1:0];
            if (wr_en && mem_addr[7:0] == IT_ADDR) it_q <= mem_wdata[NUM_SRC-1:0];
        end
    end

    assign mem_rdata     = rdata_q;
    assign mem_ready_out = 1'b1;
    assign int_req_n     = (state_q != REQ);
    assign int_so_num    = (state_q == REQ) ? vec_q : 8'h00;
    assign int_isr       = isr_q;

endmodule

// File: tb/tb_intc_nest.sv
// tb_intc_nest: scoreboard bench for intc_nest; expected read data and vectors are queued by the stimulus and checked by a monitor.
module tb_intc_nest;

    localparam int         N   = 5;
    localparam logic [7:0] IE  = 8'hA8;
    localparam logic [7:0] IP  = 8'hB8;
    localparam logic [7:0] IT  = 8'hC8;
    localparam logic [7:0] PND = 8'hC9;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         mem_sel = 1'b0;
    logic [15:0]  mem_addr = 16'h0000;
    logic         mem_we_n = 1'b1;
    logic         mem_rd_n = 1'b1;
    logic         mem_sfr_n = 1'b1;
    logic [7:0]   mem_wdata = 8'h00;
    logic [7:0]   mem_rdata;
    logic         mem_ready_out;
    logic         int_ack_n = 1'b1;
    logic         int_reti = 1'b0;
    logic         int_req_n;
    logic [7:0]   int_so_num;
    logic [N-1:0] int_src = '0;
    logic [1:0]   int_isr;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] rd_exp[$];
    logic [7:0] vec_exp[$];
    logic       rd_fire;
    logic       prev_req_n = 1'b1;

    intc_nest #(.NUM_SRC(N)) dut (
        .clk(clk), .reset_n(reset_n), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_we_n(mem_we_n), .mem_rd_n(mem_rd_n), .mem_sfr_n(mem_sfr_n),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready_out(mem_ready_out),
        .int_ack_n(int_ack_n), .int_reti(int_reti), .int_req_n(int_req_n),
        .int_so_num(int_so_num), .int_src(int_src), .int_isr(int_isr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: read data appears one cycle after a read; a vector is checked on each request assertion.
    initial begin
        forever begin
            @(posedge clk);
            rd_fire = mem_sel && !mem_sfr_n && !mem_rd_n;
            @(negedge clk);
            if (rd_fire) begin
                if (rd_exp.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got %h expected none", mem_rdata);
                end else chk("rdata", mem_rdata, rd_exp.pop_front());
            end
            if (prev_req_n === 1'b1 && int_req_n === 1'b0) begin
                if (vec_exp.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL req_unexpected: got vector %h expected no request", int_so_num);
                end else chk("vector", int_so_num, vec_exp.pop_front());
            end
            prev_req_n = int_req_n;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(1);
        mem_sel = 1'b1; mem_sfr_n = 1'b0; mem_we_n = 1'b0; mem_addr = {8'h00, a}; mem_wdata = d;
        cyc(1);
        mem_sel = 1'b0; mem_sfr_n = 1'b1; mem_we_n = 1'b1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        rd_exp.push_back(e);
        cyc(1);
        mem_sel = 1'b1; mem_sfr_n = 1'b0; mem_rd_n = 1'b0; mem_addr = {8'h00, a};
        cyc(1);
        mem_sel = 1'b0; mem_sfr_n = 1'b1; mem_rd_n = 1'b1;
    endtask

    task automatic wait_req(input string nm);
        int k = 0;
        while (int_req_n !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (int_req_n !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got no request within 20 cycles expected int_req_n=0", nm);
        end
    endtask

    task automatic ack();
        cyc(1); int_ack_n = 1'b0;
        cyc(1); int_ack_n = 1'b1;
    endtask

    task automatic reti();
        cyc(1); int_reti = 1'b1;
        cyc(1); int_reti = 1'b0;
    endtask

    task automatic ack_reti();
        cyc(1); int_ack_n = 1'b0; int_reti = 1'b1;
        cyc(1); int_ack_n = 1'b1; int_reti = 1'b0;
    endtask

    task automatic pulse(input int i);
        cyc(1); int_src[i] = 1'b1;
        cyc(1); int_src[i] = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_req_n", int_req_n, 8'h01);
        chk("rst_so_num", int_so_num, 8'h00);
        chk("rst_isr", int_isr, 8'h00);
        chk("rst_rdata", mem_rdata, 8'h00);
        chk("ready", mem_ready_out, 8'h01);
        reset_n = 1'b1;

        // level source 0
        wr(IE, 8'h81);
        vec_exp.push_back(8'h03);
        cyc(1); int_src[0] = 1'b1;
        wait_req("lvl_req");
        ack();
        chk("lvl_isr_ack", int_isr, 8'h01);
        int_src[0] = 1'b0;
        cyc(2);
        reti();
        chk("lvl_isr_reti", int_isr, 8'h00);

        // edge source 2
        wr(IT, 8'h04);
        wr(IE, 8'h84);
        vec_exp.push_back(8'h13);
        pulse(2);
        wait_req("edge_req");
        rd(PND, 8'h04);
        ack();
        chk("edge_isr_ack", int_isr, 8'h01);
        rd(PND, 8'h00);
        reti();
        chk("edge_isr_reti", int_isr, 8'h00);

        // nesting: src1 low in service, src3 high edge
        wr(IT, 8'h08);
        wr(IP, 8'h08);
        wr(IE, 8'h8A);
        vec_exp.push_back(8'h0B);
        cyc(1); int_src[1] = 1'b1;
        wait_req("nest_lo_req");
        ack();
        chk("nest_isr_lo", int_isr, 8'h01);
        int_src[1] = 1'b0;
        vec_exp.push_back(8'h1B);
        pulse(3);
        wait_req("nest_hi_req");
        ack();
        chk("nest_isr_both", int_isr, 8'h03);
        rd(PND, 8'h80);
        reti();
        chk("nest_isr_reti1", int_isr, 8'h01);
        reti();
        chk("nest_isr_reti2", int_isr, 8'h00);

        // ack and reti in the same cycle: reti clears lo, ack sets hi
        vec_exp.push_back(8'h0B);
        cyc(1); int_src[1] = 1'b1;
        wait_req("same_lo_req");
        ack();
        int_src[1] = 1'b0;
        chk("same_isr_lo", int_isr, 8'h01);
        vec_exp.push_back(8'h1B);
        pulse(3);
        wait_req("same_hi_req");
        ack_reti();
        chk("same_isr", int_isr, 8'h02);
        reti();
        chk("same_isr_end", int_isr, 8'h00);

        // blocking: second low source waits for reti
        wr(IT, 8'h00);
        wr(IP, 8'h00);
        wr(IE, 8'h86);
        vec_exp.push_back(8'h0B);
        cyc(1); int_src[1] = 1'b1;
        wait_req("blk_first_req");
        ack();
        chk("blk_isr_lo", int_isr, 8'h01);
        int_src[1] = 1'b0;
        int_src[2] = 1'b1;
        cyc(6);
        chk("blk_held", int_req_n, 8'h01);
        vec_exp.push_back(8'h13);
        reti();
        wait_req("blk_second_req");
        chk("blk_isr_free", int_isr, 8'h00);
        ack();
        chk("blk_isr_lo2", int_isr, 8'h01);
        int_src[2] = 1'b0;
        cyc(2);
        reti();
        chk("blk_isr_end", int_isr, 8'h00);

        // ack while idle is ignored
        ack();
        chk("idle_ack_isr", int_isr, 8'h00);
        chk("idle_ack_req", int_req_n, 8'h01);

        // withdrawal of a level request
        wr(IE, 8'h81);
        vec_exp.push_back(8'h03);
        cyc(1); int_src[0] = 1'b1;
        wait_req("wd_req");
        int_src[0] = 1'b0;
        cyc(4);
        chk("wd_req_n", int_req_n, 8'h01);
        chk("wd_so_num", int_so_num, 8'h00);
        chk("wd_isr", int_isr, 8'h00);

        // EA clear drops edge pend
        wr(IT, 8'h04);
        wr(IE, 8'h84);
        vec_exp.push_back(8'h13);
        pulse(2);
        wait_req("ea_req");
        wr(IE, 8'h00);
        cyc(2);
        chk("ea_withdraw", int_req_n, 8'h01);
        rd(PND, 8'h00);
        wr(IE, 8'h84);
        cyc(4);
        chk("ea_no_rereq", int_req_n, 8'h01);
        rd(PND, 8'h00);
        chk("ea_isr", int_isr, 8'h00);

        // SFR readback
        wr(IT, 8'hFF);
        rd(IT, 8'h1F);
        rd(8'h80, 8'h00);
        rd(IE, 8'h84);
        wr(IP, 8'h5A);
        rd(IP, 8'h1A);

        // reset in the middle of a request
        wr(IP, 8'h00);
        wr(IT, 8'h00);
        wr(IE, 8'h81);
        vec_exp.push_back(8'h03);
        cyc(1); int_src[0] = 1'b1;
        wait_req("rst_mid_req");
        reset_n = 1'b0;
        cyc(1);
        chk("rst_mid_req_n", int_req_n, 8'h01);
        chk("rst_mid_so_num", int_so_num, 8'h00);
        int_src[0] = 1'b0;
        reset_n = 1'b1;
        cyc(3);
        chk("rst_mid_idle", int_req_n, 8'h01);
        rd(IE, 8'h00);
        rd(IT, 8'h00);

        cyc(5);
        chk("rd_queue_left", 8'(rd_exp.size()), 8'h00);
        chk("vec_queue_left", 8'(vec_exp.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
